// File: rtl/mipi_pkg.sv
// Shared definitions for the MIPI frame-buffer writer: FSM states, RAW8 packing
// and the default 640x480 display geometry.
package mipi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FS,
        WAIT_LS,
        LINE,
        DONE
    } fw_state_t;

    localparam int RAW8_PX_PER_WORD = 4;
    localparam int DEF_H_PIXELS     = 640;
    localparam int DEF_V_LINES      = 480;
    localparam int DEF_H_WORDS      = DEF_H_PIXELS / RAW8_PX_PER_WORD;
    localparam int DEF_ADDR_W       = 17;

    // Bits needed for a counter that must be able to hold max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Linear framebuffer address generator: line_base advances by one line stride per
// written line and a column offset steps once per written word, so no multiplier is needed.
module fb_addr_gen #(
    parameter int H_WORDS = 160,
    parameter int ADDR_W  = 17
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              frame_init,
    input  logic              line_init,
    input  logic              word_step,
    input  logic              line_advance,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);

    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] col;

    // The column restarts at every line boundary, whether or not the line was written.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            line_base <= '0;
            col       <= '0;
        end else if (frame_init) begin
            line_base <= '0;
            col       <= '0;
        end else begin
            if (line_advance)
                line_base <= line_base + LINE_STRIDE;
            if (line_advance || line_init)
                col <= '0;
            else if (word_step)
                col <= col + ADDR_ONE;
        end
    end

    assign addr = line_base + col;

endmodule

// File: rtl/mipi_frame_writer.sv
// Frame-buffer write controller: crops CSI RAW8 payload to the display window and
// emits linear word writes, with single-shot/continuous capture and sticky error flags.
module mipi_frame_writer
    import mipi_pkg::*;
#(
    parameter int H_WORDS = DEF_H_WORDS,
    parameter int V_LINES = DEF_V_LINES,
    parameter int H_SKIP  = 0,
    parameter int V_SKIP  = 0,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              continuous,
    input  logic              arm,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              line_start,
    input  logic              data_valid,
    input  logic [31:0]       data_in,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_data,
    output logic              ram_we,
    output logic              busy,
    output logic              frame_done,
    output logic              short_line,
    output logic              short_frame,
    output logic              overrun
);
    localparam int LINE_LIMIT  = H_SKIP + H_WORDS;
    localparam int FRAME_LIMIT = V_SKIP + V_LINES;
    localparam int WC_W = cnt_width(LINE_LIMIT);
    localparam int LC_W = cnt_width(FRAME_LIMIT);
    localparam int WL_W = cnt_width(V_LINES);

    localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);
    localparam logic [WC_W-1:0] WC_MAX  = '1;
    localparam logic [WC_W-1:0] H_LO    = WC_W'(H_SKIP);
    localparam logic [WC_W-1:0] H_SPAN  = WC_W'(H_WORDS);
    localparam logic [WC_W-1:0] H_END   = WC_W'(LINE_LIMIT);
    localparam logic [LC_W-1:0] LC_ONE  = LC_W'(1);
    localparam logic [LC_W-1:0] LC_MAX  = '1;
    localparam logic [LC_W-1:0] V_LO    = LC_W'(V_SKIP);
    localparam logic [LC_W-1:0] V_SPAN  = LC_W'(V_LINES);
    localparam logic [WL_W-1:0] WL_ONE  = WL_W'(1);
    localparam logic [WL_W-1:0] WL_MAX  = '1;
    localparam logic [WL_W-1:0] WL_FULL = WL_W'(V_LINES);

    fw_state_t state, state_next;

    logic [WC_W-1:0]   word_cnt, word_inc, words_seen;
    logic [LC_W-1:0]   line_cnt, line_inc;
    logic [WL_W-1:0]   wr_line, wr_line_inc, wr_line_after;
    logic [WC_W:0]     word_off;
    logic [LC_W:0]     line_off;
    logic              beat, line_written, word_in_window, do_write;
    logic              line_close, start_line, frame_init, clear_flags, fe_accept;
    logic [ADDR_W-1:0] gen_addr;

    assign word_inc    = (word_cnt == WC_MAX) ? word_cnt : word_cnt + WC_ONE;
    assign line_inc    = (line_cnt == LC_MAX) ? line_cnt : line_cnt + LC_ONE;
    assign wr_line_inc = (wr_line == WL_MAX) ? wr_line : wr_line + WL_ONE;

    // Window tests via a borrow bit so a zero crop offset needs no special case.
    assign beat           = (state == LINE) && data_valid;
    assign words_seen     = beat ? word_inc : word_cnt;
    assign line_off       = {1'b0, line_cnt} - {1'b0, V_LO};
    assign line_written   = !line_off[LC_W] && (line_off[LC_W-1:0] < V_SPAN);
    assign word_off       = {1'b0, word_cnt} - {1'b0, H_LO};
    assign word_in_window = !word_off[WC_W] && (word_off[WC_W-1:0] < H_SPAN);
    assign do_write       = beat && line_written && word_in_window;
    assign wr_line_after  = (line_close && line_written) ? wr_line_inc : wr_line;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A sync arriving with a payload beat acts after the beat has been consumed,
    // so a line_start in LINE closes the old line and opens the next one at once.
    always_comb begin
        state_next  = state;
        line_close  = 1'b0;
        start_line  = 1'b0;
        frame_init  = 1'b0;
        clear_flags = 1'b0;
        fe_accept   = 1'b0;
        case (state)
            IDLE: begin
                if (continuous || arm) begin
                    state_next  = WAIT_FS;
                    clear_flags = 1'b1;
                end
            end
            WAIT_FS: begin
                if (frame_start) begin
                    state_next = WAIT_LS;
                    frame_init = 1'b1;
                end
            end
            WAIT_LS: begin
                if (frame_end) begin
                    state_next = DONE;
                    fe_accept  = 1'b1;
                end else if (line_start) begin
                    state_next = LINE;
                    start_line = 1'b1;
                end
            end
            LINE: begin
                if (frame_end) begin
                    state_next = DONE;
                    line_close = 1'b1;
                    fe_accept  = 1'b1;
                end else if (line_start) begin
                    line_close = 1'b1;
                    start_line = 1'b1;
                end else if (words_seen == H_END) begin
                    state_next = WAIT_LS;
                    line_close = 1'b1;
                end
            end
            DONE: begin
                state_next = continuous ? WAIT_FS : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            word_cnt <= '0;
            line_cnt <= '0;
            wr_line  <= '0;
        end else if (frame_init) begin
            word_cnt <= '0;
            line_cnt <= '0;
            wr_line  <= '0;
        end else begin
            if (start_line)
                word_cnt <= '0;
            else if (beat)
                word_cnt <= word_inc;
            if (line_close) begin
                line_cnt <= line_inc;
                wr_line  <= wr_line_after;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            short_line  <= 1'b0;
            short_frame <= 1'b0;
            overrun     <= 1'b0;
        end else if (clear_flags) begin
            short_line  <= 1'b0;
            short_frame <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (line_close && line_written && (words_seen < H_END))
                short_line <= 1'b1;
            if (fe_accept && (wr_line_after < WL_FULL))
                short_frame <= 1'b1;
            if ((frame_start || frame_end || line_start) && data_valid)
                overrun <= 1'b1;
        end
    end

    fb_addr_gen #(
        .H_WORDS (H_WORDS),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .frame_init   (frame_init),
        .line_init    (start_line),
        .word_step    (do_write),
        .line_advance (line_close && line_written),
        .addr         (gen_addr)
    );

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else begin
            ram_we <= do_write;
            if (do_write) begin
                ram_addr <= gen_addr;
                ram_data <= data_in;
            end
        end
    end

    assign busy       = (state == WAIT_LS) || (state == LINE);
    assign frame_done = (state == DONE);

endmodule

// File: tb/tb_mipi_frame_writer.sv
// Scoreboard bench for mipi_frame_writer: random frames are expanded by a line/word
// reference model into expected writes, and a negedge monitor compares every RAM write.
module tb_mipi_frame_writer;
    localparam int H_WORDS   = 8;
    localparam int V_LINES   = 6;
    localparam int H_SKIP    = 2;
    localparam int V_SKIP    = 1;
    localparam int ADDR_W    = 8;
    localparam int LIMIT     = H_SKIP + H_WORDS;
    localparam int MAX_LINES = 12;
    localparam int MAX_WORDS = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              sys_clk = 1'b0;
    logic              reset = 1'b1;
    logic              continuous = 1'b0;
    logic              arm = 1'b0;
    logic              frame_start = 1'b0;
    logic              frame_end = 1'b0;
    logic              line_start = 1'b0;
    logic              data_valid = 1'b0;
    logic [31:0]       data_in = '0;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_data;
    logic              ram_we, busy, frame_done, short_line, short_frame, overrun;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  done_seen = 0;
    int  done_exp = 0;
    bit  m_short_line, m_short_frame, m_overrun;

    mipi_frame_writer #(
        .H_WORDS (H_WORDS),
        .V_LINES (V_LINES),
        .H_SKIP  (H_SKIP),
        .V_SKIP  (V_SKIP),
        .ADDR_W  (ADDR_W)
    ) dut (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .continuous  (continuous),
        .arm         (arm),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .line_start  (line_start),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_we      (ram_we),
        .busy        (busy),
        .frame_done  (frame_done),
        .short_line  (short_line),
        .short_frame (short_frame),
        .overrun     (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Writes and frame completions are checked here, decoupled from the driver.
    always @(negedge sys_clk) begin
        wr_t e;
        if (!reset) begin
            if (ram_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_write addr=%0h data=%0h expected no write", ram_addr, ram_data);
                end else begin
                    e = exp_q.pop_front();
                    check_output("ram_write", {ram_addr, ram_data}, {e.addr, e.data});
                end
            end
            if (frame_done) begin
                done_seen++;
                check_output("busy_at_done", busy, 1'b0);
            end
        end
    end

    task automatic apply_stimulus(input bit fs, input bit fe, input bit ls, input bit dv,
                                  input logic [31:0] d, input bit a);
        frame_start = fs;
        frame_end   = fe;
        line_start  = ls;
        data_valid  = dv;
        data_in     = d;
        arm         = a;
        @(posedge sys_clk);
        #1;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        line_start  = 1'b0;
        data_valid  = 1'b0;
        arm         = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic clear_model();
        m_short_line  = 1'b0;
        m_short_frame = 1'b0;
        m_overrun     = 1'b0;
    endtask

    task automatic arm_capture();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        clear_model();
    endtask

    task automatic check_all_zero(input string name);
        check_output(name, {ram_addr, ram_data, ram_we, busy, frame_done, short_line, short_frame, overrun}, 64'h0);
    endtask

    task automatic check_flags();
        check_output("short_line", short_line, m_short_line);
        check_output("short_frame", short_frame, m_short_frame);
        check_output("overrun", overrun, m_overrun);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_seen < done_exp && n < 50) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        check_output("frame_done_count", done_seen, done_exp);
    endtask

    // One CSI frame: n_lines lines of len words each; a merged line hands its last
    // word to the following sync pulse (line_start or frame_end).
    task automatic run_frame(input bit capture, input int n_lines, input int fixed_len,
                             input bit allow_merge, input bit arm_mid, input bit drop_cont);
        logic [31:0] pix [MAX_LINES][MAX_WORDS];
        int          len [MAX_LINES];
        bit          merge [MAX_LINES];
        bit          pend_v;
        logic [31:0] pend_d;
        int          written;
        wr_t         e;
        for (int i = 0; i < n_lines; i++) begin
            len[i]   = (fixed_len >= 0) ? fixed_len : int'($urandom_range(0, LIMIT + 3));
            merge[i] = allow_merge && (len[i] > 0) && ($urandom_range(0, 2) == 0);
            for (int k = 0; k < MAX_WORDS; k++)
                pix[i][k] = $urandom();
        end
        if (capture) begin
            for (int i = V_SKIP; i < n_lines && i < V_SKIP + V_LINES; i++) begin
                for (int k = H_SKIP; k < LIMIT && k < len[i]; k++) begin
                    e.addr = ADDR_W'((i - V_SKIP) * H_WORDS + (k - H_SKIP));
                    e.data = pix[i][k];
                    exp_q.push_back(e);
                end
                if (len[i] < LIMIT)
                    m_short_line = 1'b1;
            end
            written = n_lines - V_SKIP;
            if (written < 0) written = 0;
            if (written > V_LINES) written = V_LINES;
            if (written < V_LINES)
                m_short_frame = 1'b1;
            done_exp++;
        end
        for (int i = 0; i < n_lines; i++)
            if (merge[i]) m_overrun = 1'b1;

        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_output("busy_after_fs", busy, capture);
        if (drop_cont)
            continuous = 1'b0;
        idle($urandom_range(0, 2));
        pend_v = 1'b0;
        pend_d = '0;
        for (int i = 0; i < n_lines; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, pend_v, pend_d, 1'b0);
            pend_v = 1'b0;
            for (int k = 0; k < len[i]; k++) begin
                if (merge[i] && k == len[i] - 1) begin
                    pend_v = 1'b1;
                    pend_d = pix[i][k];
                end else begin
                    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, pix[i][k], 1'b0);
                end
                if ($urandom_range(0, 4) == 0)
                    apply_stimulus($urandom_range(0, 2) == 0, 1'b0, 1'b0, 1'b0, 32'h0, arm_mid);
            end
        end
        apply_stimulus(1'b0, 1'b1, 1'b0, pend_v, pend_d, 1'b0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] d;
        wr_t         e;
        clear_model();
        repeat (3) @(posedge sys_clk);
        #1;
        check_all_zero("reset_state");
        reset = 1'b0;
        idle(2);

        // Clean frame: every window word written in order, no flags.
        arm_capture();
        run_frame(1'b1, V_SKIP + V_LINES, LIMIT, 1'b0, 1'b0, 1'b0);
        wait_done();
        check_flags();

        // Overlong lines and surplus lines are dropped silently.
        arm_capture();
        run_frame(1'b1, V_SKIP + V_LINES + 2, LIMIT + 2, 1'b0, 1'b0, 1'b0);
        wait_done();
        check_flags();

        // Frame ends early.
        arm_capture();
        run_frame(1'b1, 3, LIMIT, 1'b0, 1'b0, 1'b0);
        wait_done();
        check_flags();

        repeat (8) begin
            arm_capture();
            run_frame(1'b1, $urandom_range(0, 9), -1, 1'b1, 1'b1, 1'b0);
            wait_done();
            check_flags();
        end

        // Mid-frame arm pulses were ignored, so this frame must not be captured.
        run_frame(1'b0, 4, -1, 1'b1, 1'b0, 1'b0);
        idle(3);
        check_output("unarmed_queue_empty", exp_q.size(), 0);

        continuous = 1'b1;
        clear_model();
        idle(2);
        repeat (5) begin
            run_frame(1'b1, $urandom_range(0, 9), -1, 1'b1, 1'b0, 1'b0);
            wait_done();
            check_flags();
        end
        run_frame(1'b1, $urandom_range(2, 9), -1, 1'b1, 1'b0, 1'b1);
        wait_done();
        check_flags();
        idle(2);
        run_frame(1'b0, 3, -1, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_output("after_cont_drop_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a written line.
        arm_capture();
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            d = $urandom();
            if (k >= H_SKIP) begin
                e.addr = ADDR_W'(k - H_SKIP);
                e.data = d;
                exp_q.push_back(e);
            end
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, d, 1'b0);
        end
        data_valid = 1'b1;
        data_in    = $urandom();
        @(negedge sys_clk);
        #1;
        reset = 1'b1;
        @(posedge sys_clk);
        #1;
        data_valid = 1'b0;
        check_all_zero("reset_mid_line");
        check_output("reset_queue_empty", exp_q.size(), 0);
        idle(1);
        reset = 1'b0;
        clear_model();
        idle(2);
        run_frame(1'b0, 3, -1, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_output("post_reset_no_writes", exp_q.size(), 0);

        check_output("final_done_count", done_seen, done_exp);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
